mem_write_tracer: RTL and testbench

Parametrised, synthesizable successor to the bench-side memory-write monitor of the pipelined processor. Sits beside the data memory, snoops every write (addr, data), and starts capturing at a programmable trigger address. Captured writes, each with a cycle timestamp, go into a first-word-fall-through FIFO drained by a valid/ready port. Supports a capture limit, stop/re-arm, overflow and drop accounting, so fibExample-style runs can be checked on-chip or in simulation without $monitor.

---
 rtl/mem_write_tracer.sv | 192 +++++++++++++++++++
 tb/tb_mem_write_tracer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_tracer.sv
// -----------------------------------------------------------------------------
// mem_write_tracer
//   Snoops data-memory writes and, once armed and triggered, records each
//   (address, data, cycle stamp) into a first-word-fall-through FIFO that a
//   consumer drains over a valid/ready port. Tracks accepted and dropped
//   writes and ends capture on stop, on a programmable entry limit, or on a
//   re-arm.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   arm        pulse: flush FIFO, clear counters, go to ARMED
//   stop       pulse: end capture (ARMED/CAPTURE -> DONE)
//   trig_any   1 = any write triggers, 0 = only writes to trig_addr
//   trig_addr  trigger address
//   mem_we     snooped write strobe
//   mem_addr   snooped write address
//   mem_wdata  snooped write data
//   rd_ready   consumer ready
//   rd_valid   FIFO head valid
//   rd_addr    head entry address (0 when empty)
//   rd_data    head entry data (0 when empty)
//   rd_stamp   head entry timestamp (0 when empty)
//   state      IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   count      entries accepted since last arm, saturating
//   dropped    eligible writes lost to a full FIFO, saturating
//   overflow   sticky: at least one drop since last arm
// -----------------------------------------------------------------------------
module mem_write_tracer #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int STAMP_WIDTH   = 32,
    parameter int CAPTURE_LIMIT = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   trig_any,
    input  logic [ADDR_WIDTH-1:0]  trig_addr,
    input  logic                   mem_we,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [STAMP_WIDTH-1:0] rd_stamp,
    output logic [1:0]             state,
    output logic [CNT_WIDTH-1:0]   count,
    output logic [CNT_WIDTH-1:0]   dropped,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [STAMP_WIDTH-1:0] stamp_q;
    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d, dropped_q, dropped_d;
    logic                   overflow_q, overflow_d;

    logic [ADDR_WIDTH-1:0]  addr_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0]  data_mem_q  [DEPTH];
    logic [STAMP_WIDTH-1:0] stamp_mem_q [DEPTH];

    logic empty, full, pop, push, eligible, limit_hit;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop   = !empty && rd_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push  = eligible && (!full || pop);
    // The accepting write that brings count up to the limit ends capture.
    assign limit_hit = push && (CAPTURE_LIMIT != 0) &&
                       ((int'(count_q) + 1) == CAPTURE_LIMIT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (stop)          state_d = S_DONE;
                    else if (eligible) state_d = limit_hit ? S_DONE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (stop || limit_hit) state_d = S_DONE;
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM: outputs (write eligibility) ----------------
    always_comb begin
        eligible = 1'b0;
        if (mem_we && !arm && !stop) begin
            case (state_q)
                S_ARMED:   eligible = trig_any || (mem_addr == trig_addr);
                S_CAPTURE: eligible = 1'b1;
                default:   eligible = 1'b0;
            endcase
        end
    end

    // ---------------- FIFO pointers and counters ----------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        if (arm) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            dropped_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != '1) count_d = count_q + 1'b1;
            end else if (eligible) begin
                if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
                overflow_d = 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stamp_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            stamp_q    <= stamp_q + 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage has no reset; pointers alone define which entries are
    // live, and the read port is gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q[PTR_W-1:0]]  <= mem_addr;
            data_mem_q[wr_ptr_q[PTR_W-1:0]]  <= mem_wdata;
            stamp_mem_q[wr_ptr_q[PTR_W-1:0]] <= stamp_q;
        end
    end

    // ---------------- Outputs ----------------
    assign rd_valid = !empty;
    assign rd_addr  = rd_valid ? addr_mem_q[rd_ptr_q[PTR_W-1:0]]  : '0;
    assign rd_data  = rd_valid ? data_mem_q[rd_ptr_q[PTR_W-1:0]]  : '0;
    assign rd_stamp = rd_valid ? stamp_mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
    assign state    = state_q;
    assign count    = count_q;
    assign dropped  = dropped_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_write_tracer.sv
// -----------------------------------------------------------------------------
// tb_mem_write_tracer
//   Directed bench for mem_write_tracer. Writes the bench expects to be
//   accepted are pushed to a scoreboard with their expected stamp; every pop
//   on the read port is compared against the scoreboard head. A second
//   instance with CAPTURE_LIMIT=3 shares the stimulus for the limit checks.
// -----------------------------------------------------------------------------
module tb_mem_write_tracer;

    logic        clk = 1'b0;
    logic        reset, arm, stop, trig_any, mem_we, rd_ready, rd_ready_l;
    logic [31:0] trig_addr, mem_addr, mem_wdata;

    logic        rd_valid, overflow;
    logic [31:0] rd_addr, rd_data, rd_stamp;
    logic [1:0]  state;
    logic [15:0] count, dropped;

    logic        l_rd_valid, l_overflow;
    logic [31:0] l_rd_addr, l_rd_data, l_rd_stamp;
    logic [1:0]  l_state;
    logic [15:0] l_count, l_dropped;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] stamp;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] exp_stamp = '0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_write_tracer dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop),
        .trig_any(trig_any), .trig_addr(trig_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_stamp(rd_stamp), .state(state),
        .count(count), .dropped(dropped), .overflow(overflow)
    );

    mem_write_tracer #(.CAPTURE_LIMIT(3)) dut_l (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop),
        .trig_any(trig_any), .trig_addr(trig_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_ready(rd_ready_l), .rd_valid(l_rd_valid), .rd_addr(l_rd_addr),
        .rd_data(l_rd_data), .rd_stamp(l_rd_stamp), .state(l_state),
        .count(l_count), .dropped(l_dropped), .overflow(l_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare any pop happening this cycle, advance the edge,
    // track the expected free-running stamp, then settle 1 time unit.
    task automatic step();
        ent_t e;
        if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rd_addr", rd_addr, e.addr);
                check("rd_data", rd_data, e.data);
                check("rd_stamp", rd_stamp, e.stamp);
            end
        end
        @(posedge clk);
        if (!reset) exp_stamp = '0;
        else        exp_stamp = exp_stamp + 1;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit acc);
        ent_t e;
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        if (acc) begin
            e.addr = a; e.data = d; e.stamp = exp_stamp;
            sb.push_back(e);
        end
        step();
        mem_we = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() > 0; i++) step();
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0; arm = 1'b0; stop = 1'b0; trig_any = 1'b0;
        trig_addr = '0; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'h5;
        rd_ready = 1'b0; rd_ready_l = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a write present
        step(); step();
        check("rst_state", state, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_dropped", dropped, 0);
        check("rst_overflow", overflow, 0);
        check("rst_addr", rd_addr, 0);
        reset = 1'b1; mem_we = 1'b0;
        step();

        // Address trigger
        trig_addr = 32'h10; trig_any = 1'b0; rd_ready = 1'b1;
        do_arm();
        check("trg_armed", state, 1);
        wr(32'h0C, 32'h11, 1'b0);
        check("trg_still_armed", state, 1);
        wr(32'h10, 32'h22, 1'b1);
        check("trg_capture", state, 2);
        step();
        wr(32'h14, 32'h33, 1'b1);
        drain("trg_drain");
        check("trg_count", count, 2);

        // Overflow: 20 writes into a 16-entry FIFO with no consumer
        trig_any = 1'b1; rd_ready = 1'b0;
        do_arm();
        for (int i = 0; i < 20; i++) wr(32'h100 + 32'(i) * 4, 32'(i), i < 16);
        check("ovf_count", count, 16);
        check("ovf_dropped", dropped, 4);
        check("ovf_flag", overflow, 1);
        rd_ready = 1'b1;
        wr(32'h200, 32'hAA, 1'b1);
        check("ovf_fullpop_dropped", dropped, 4);
        check("ovf_fullpop_count", count, 17);
        drain("ovf_drain");
        check("ovf_empty", rd_valid, 0);

        // Capture limit on the second instance
        rd_ready_l = 1'b0;
        do_arm();
        wr(32'h300, 32'h1, 1'b1);
        check("lim_state1", l_state, 2);
        wr(32'h304, 32'h2, 1'b1);
        wr(32'h308, 32'h3, 1'b1);
        check("lim_done", l_state, 3);
        check("lim_count3", l_count, 3);
        wr(32'h30C, 32'h4, 1'b1);
        wr(32'h310, 32'h5, 1'b1);
        check("lim_count_final", l_count, 3);
        check("lim_main_count", count, 5);
        drain("lim_main_drain");
        rd_ready_l = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (l_rd_valid) begin
                check("lim_rd_addr", l_rd_addr, 32'h300 + 32'(n) * 4);
                n++;
            end
            step();
        end
        check("lim_entries", n, 3);
        rd_ready_l = 1'b0;

        // Stop in the same cycle as a write
        do_arm();
        wr(32'h400, 32'h1, 1'b1);
        check("stp_capture", state, 2);
        stop = 1'b1;
        wr(32'h404, 32'h2, 1'b0);
        stop = 1'b0;
        check("stp_done", state, 3);
        check("stp_count", count, 1);
        drain("stp_drain");
        wr(32'h408, 32'h3, 1'b0);
        check("stp_done_ignore", count, 1);
        check("stp_done_empty", rd_valid, 0);

        // arm and stop together, with entries queued
        rd_ready = 1'b0;
        do_arm();
        wr(32'h500, 32'h1, 1'b1);
        wr(32'h504, 32'h2, 1'b1);
        arm = 1'b1; stop = 1'b1;
        step();
        arm = 1'b0; stop = 1'b0;
        sb.delete();
        check("as_state", state, 1);
        check("as_valid", rd_valid, 0);
        check("as_count", count, 0);
        check("as_dropped", dropped, 0);
        check("as_overflow", overflow, 0);

        // Reset mid-capture
        for (int i = 0; i < 5; i++) wr(32'h600 + 32'(i), 32'(i), 1'b1);
        check("rmc_count", count, 5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        sb.delete();
        check("rmc_valid", rd_valid, 0);
        check("rmc_state", state, 0);
        check("rmc_count0", count, 0);
        do_arm();
        rd_ready = 1'b1;
        wr(32'h700, 32'h77, 1'b1);
        drain("rmc_stamp_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
